// File: rtl/lib_voq_requester.sv
// lib_voq_requester: per-destination virtual output queues issuing requests to an allocator
module lib_voq_requester #(
    parameter int M     = 4,
    parameter int D     = 4,
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     i_data,
    input  logic                 i_data_val,
    input  logic [$clog2(M)-1:0] i_dest,
    output logic                 o_data_ready,
    output logic [0:M-1]         o_request,
    input  logic [0:M-1]         i_grant,
    output logic [WIDTH-1:0]     o_data,
    output logic                 o_data_val,
    output logic [$clog2(M)-1:0] o_dest,
    output logic                 o_error
);
    localparam int AW = $clog2(D);
    localparam int DW = $clog2(M);
    localparam logic [AW:0] FULL = (AW + 1)'(D);

    logic [WIDTH-1:0] mem [M][D];
    logic [AW:0]      cnt [M];
    logic [AW-1:0]    rp  [M];
    logic [AW-1:0]    wp  [M];
    logic [DW-1:0]    gidx;
    logic             onehot;
    logic             legal;
    logic             enq;

    // decode the granted VOQ index and whether the grant and the incoming packet are honoured
    always_comb begin
        gidx = '0;
        for (int m = 0; m < M; m++)
            if (i_grant[m]) gidx = DW'(m);
        onehot       = $onehot(i_grant);
        legal        = onehot && cnt[gidx] != '0;
        o_data_ready = cnt[i_dest] < FULL || (cnt[i_dest] == FULL && onehot && gidx == i_dest);
        enq          = i_data_val && o_data_ready;
    end

    // requests come only from registered occupancy, never from grant or input paths
    always_comb begin
        o_request = '0;
        for (int m = 0; m < M; m++)
            o_request[m] = cnt[m] != '0;
    end

    // packet storage needs no reset; stale entries are unreachable once pointers clear
    always_ff @(posedge clk) begin
        if (!reset && enq)
            mem[i_dest][wp[i_dest]] <= i_data;
    end

    // pointer/count bookkeeping per VOQ and the registered dequeue output
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int m = 0; m < M; m++) begin
                cnt[m] <= '0;
                rp[m]  <= '0;
                wp[m]  <= '0;
            end
            o_data_val <= 1'b0;
            o_data     <= '0;
            o_dest     <= '0;
            o_error    <= 1'b0;
        end else begin
            for (int m = 0; m < M; m++) begin
                if (enq && i_dest == DW'(m))
                    wp[m] <= wp[m] + 1'b1;
                if (legal && gidx == DW'(m))
                    rp[m] <= rp[m] + 1'b1;
                cnt[m] <= (enq && i_dest == DW'(m)) && !(legal && gidx == DW'(m)) ? cnt[m] + 1'b1 :
                          !(enq && i_dest == DW'(m)) && (legal && gidx == DW'(m)) ? cnt[m] - 1'b1 : cnt[m];
            end
            o_data_val <= legal;
            if (legal) begin
                o_data <= mem[gidx][rp[gidx]];
                o_dest <= gidx;
            end
            o_error <= o_error || (i_grant != '0 && !legal);
        end
    end
endmodule

// File: doc/lib_voq_requester.md
LIB_VOQ_REQUESTER -- requirements
Module: LIB_VOQ_Requester

Interface
REQ-001 Parameter M, default 4: number of resources (allocator outputs) and virtual output queues (VOQs).
REQ-002 Parameter D, default 4: depth of each VOQ in packets; power of two, >= 2.
REQ-003 Parameter WIDTH, default 32: packet data width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 i_data  input  WIDTH  packet to enqueue.
REQ-007 i_data_val  input  1  i_data and i_dest are valid this cycle.
REQ-008 i_dest  input  $clog2(M)  destination resource index of i_data.
REQ-009 o_data_ready  output  1  combinational; VOQ[i_dest] can accept a packet this cycle.
REQ-010 o_request  output  [0:M-1]  request vector to the allocator; bit m = VOQ m wants resource m.
REQ-011 i_grant  input  [0:M-1]  grant vector from the allocator for this requester.
REQ-012 o_data  output  WIDTH  registered dequeued packet.
REQ-013 o_data_val  output  1  registered; o_data and o_dest valid.
REQ-014 o_dest  output  $clog2(M)  registered resource index of o_data.
REQ-015 o_error  output  1  sticky protocol-violation flag.

Function
REQ-016 Each VOQ m shall be a circular buffer of D entries with read pointer, write pointer and count (0..D, $clog2(D)+1 bits); pointers wrap from D-1 to 0.
REQ-017 o_data_ready shall equal (count[i_dest] < D), or (count[i_dest] == D and i_grant is exactly one-hot on bit i_dest).
REQ-018 Enqueue shall occur when i_data_val && o_data_ready: write i_data at VOQ[i_dest] write pointer, advance pointer.
REQ-019 i_data_val with o_data_ready low shall be dropped with no state change; the source holds i_data until accepted.
REQ-020 o_request[m] shall equal (count[m] != 0), derived only from registered state; no combinational path from i_grant or i_data_val.
REQ-021 A legal grant is an exactly one-hot i_grant at bit g with count[g] != 0.
REQ-022 On a legal grant at cycle t: VOQ[g] head dequeued; o_data = head, o_dest = g, o_data_val = 1 at cycle t+1.
REQ-023 o_data_val shall be 0 in any cycle not following a legal grant; o_data and o_dest hold their previous values.
REQ-024 Enqueue and dequeue on the same VOQ in one cycle shall leave count unchanged and move both pointers; a full VOQ granted in that cycle also accepts.
REQ-025 An enqueue into an empty VOQ at cycle t shall raise o_request at t+1; grant-then-dequeue of the last entry at t shall drop o_request at t+1.
REQ-026 Multi-hot i_grant shall be ignored (no dequeue) and shall set o_error.
REQ-027 A one-hot grant to an empty VOQ shall be ignored and shall set o_error.
REQ-028 An all-zero i_grant is legal and causes no dequeue.
REQ-029 o_error, once set, shall remain 1 until reset.

Reset
REQ-030 While reset is high at a clock edge: all counts, pointers, o_data_val, o_data, o_dest and o_error shall become 0.
REQ-031 During reset, o_request shall be all-zero from the following cycle; enqueue and grant inputs in the reset cycle shall be ignored.
REQ-032 Reset asserted mid-operation shall discard all queued packets; no o_data_val pulse follows a grant presented in the reset cycle.

Verification
REQ-033 M=4, D=4: enqueue 0xA1,0xA2 to dest 2, then i_grant=0010 two cycles -> o_request=0010 until the second grant; o_data 0xA1 then 0xA2 with o_dest=2, one cycle after each grant; o_request=0000 afterward.
REQ-034 Fill VOQ 1 with 4 packets -> o_data_ready=0 for i_dest=1; a 5th packet with i_grant=0100 in the same cycle is accepted; count stays 4 and order is preserved.
REQ-035 Enqueue to dest 0 and grant VOQ 3 in the same cycle (VOQ 3 non-empty) -> both occur; o_request[0] rises next cycle, o_dest=3 with o_data_val.
REQ-036 i_grant=1100 with both VOQs non-empty -> no dequeue, o_data_val=0, o_error=1 and stays 1; a later grant to an empty VOQ also leaves counts unchanged.
REQ-037 Write 2*D packets through one VOQ with interleaved grants -> pointer wrap-around gives in-order data with no loss or duplication.
REQ-038 Assert reset with 3 VOQs non-empty and a grant present -> next cycle o_request=0000, o_data_val=0, o_error=0, and all o_data_ready=1.
